// File: rtl/debug_pkg.sv
// Shared state/section encodings and frame geometry for the debug dump path.
// Pure declarations; no timing or flow-control behaviour of its own.
package debug_pkg;

    localparam int DATA_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = DATA_W / BYTE_W;

    typedef enum logic [7:0] {
        ST_IDLE    = 8'b0000_0001,
        ST_FETCH   = 8'b0000_0010,
        ST_WAIT_RD = 8'b0000_0100,
        ST_LOAD    = 8'b0000_1000,
        ST_SEND    = 8'b0001_0000,
        ST_WAIT_TX = 8'b0010_0000,
        ST_NEXT    = 8'b0100_0000,
        ST_DONE    = 8'b1000_0000
    } state_t;

    typedef enum logic [1:0] {
        SEC_PC  = 2'd0,
        SEC_CYC = 2'd1,
        SEC_REG = 2'd2,
        SEC_MEM = 2'd3
    } section_t;

    // PC and cycle-count words precede the GPR and memory words.
    function automatic int frame_bytes(input int n_reg, input int n_mem);
        return BYTES_PER_WORD * (2 + n_reg + n_mem);
    endfunction

endpackage

// File: rtl/debug_word_serializer.sv
// Sends one loaded word MSB byte first through a start/done byte handshake.
// Start pulse 1 cycle after load, next byte 2 cycles after tx_done; waits indefinitely on tx_done.
module debug_word_serializer
    import debug_pkg::*;
#(
    parameter int DAT_W = 32,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_vld,
    input  logic [DAT_W-1:0] load_dat,
    input  logic             tx_done,
    output logic             tx_start,
    output logic [OUT_W-1:0] tx_dat,
    output logic             word_done
);

    localparam int NBYTES = DAT_W / OUT_W;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

    state_t             phase_q, phase_d;
    logic [DAT_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic               tx_start_q, tx_start_d;
    logic [OUT_W-1:0]   tx_dat_q, tx_dat_d;

    always_comb begin
        phase_d    = phase_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        word_done  = 1'b0;
        case (phase_q)
            ST_SEND:    phase_d = ST_WAIT_TX;
            ST_WAIT_TX: if (tx_done) phase_d = ST_NEXT;
            ST_NEXT: begin
                if (byte_cnt_q != LAST_BYTE) begin
                    shift_d    = shift_q << OUT_W;
                    byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    phase_d    = ST_SEND;
                end else begin
                    word_done = 1'b1;
                    phase_d   = ST_IDLE;
                end
            end
            default:    phase_d = ST_IDLE;
        endcase
        if (load_vld) begin
            shift_d    = load_dat;
            byte_cnt_d = '0;
            phase_d    = ST_SEND;
        end
        // Byte output is held for the full SEND..WAIT_TX window, zero elsewhere.
        tx_start_d = (phase_d == ST_SEND);
        tx_dat_d   = (phase_d == ST_SEND || phase_d == ST_WAIT_TX) ? shift_d[DAT_W-1 -: OUT_W] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q    <= ST_IDLE;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            tx_start_q <= 1'b0;
            tx_dat_q   <= '0;
        end else begin
            phase_q    <= phase_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            tx_start_q <= tx_start_d;
            tx_dat_q   <= tx_dat_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_dat   = tx_dat_q;

endmodule

// File: rtl/debug_dump_sequencer.sv
// Streams PC, cycle count, GPRs and leading data-memory words to the UART TX.
// First start 4 cycles after accept; stalls on i_tx_done; requests outside IDLE are dropped.
module debug_dump_sequencer
    import debug_pkg::*;
#(
    parameter int OUTPUT_WORD_LENGTH    = 8,
    parameter int LONGITUD_DATO         = 32,
    parameter int CANT_REGISTROS        = 32,
    parameter int ADDR_REG_LENGTH       = 5,
    parameter int CANT_PALABRAS_MEM     = 16,
    parameter int ADDR_MEM_DATOS_LENGTH = 10
) (
    input  logic                             i_clock,
    input  logic                             i_reset,
    input  logic                             i_start_dump,
    input  logic [LONGITUD_DATO-1:0]         i_pc,
    input  logic [LONGITUD_DATO-1:0]         i_contador_ciclos,
    output logic [ADDR_REG_LENGTH-1:0]       o_addr_reg,
    input  logic [LONGITUD_DATO-1:0]         i_dato_reg,
    output logic [ADDR_MEM_DATOS_LENGTH-1:0] o_addr_mem_datos,
    input  logic [LONGITUD_DATO-1:0]         i_dato_mem_datos,
    output logic                             o_tx_start,
    output logic [OUTPUT_WORD_LENGTH-1:0]    o_data_tx,
    input  logic                             i_tx_done,
    output logic                             o_busy,
    output logic                             o_dump_done
);

    localparam int CANT_MAX = (CANT_REGISTROS > CANT_PALABRAS_MEM) ? CANT_REGISTROS : CANT_PALABRAS_MEM;
    localparam int ITEM_W   = $clog2(CANT_MAX) + 1;
    localparam logic [ITEM_W-1:0] LAST_REG = ITEM_W'(CANT_REGISTROS - 1);
    localparam logic [ITEM_W-1:0] LAST_MEM = ITEM_W'(CANT_PALABRAS_MEM - 1);

    state_t                           state_q, state_d;
    section_t                         section_q, section_d;
    logic [ITEM_W-1:0]                item_q, item_d;
    logic [LONGITUD_DATO-1:0]         pc_snap_q, pc_snap_d;
    logic [LONGITUD_DATO-1:0]         cyc_snap_q, cyc_snap_d;
    logic [ADDR_REG_LENGTH-1:0]       addr_reg_q, addr_reg_d;
    logic [ADDR_MEM_DATOS_LENGTH-1:0] addr_mem_q, addr_mem_d;
    logic                             busy_q, busy_d;
    logic                             done_q, done_d;

    logic                     load_vld;
    logic [LONGITUD_DATO-1:0] load_dat;
    logic                     word_done;

    assign load_vld = (state_q == ST_LOAD);

    always_comb begin
        case (section_q)
            SEC_PC:  load_dat = pc_snap_q;
            SEC_CYC: load_dat = cyc_snap_q;
            SEC_REG: load_dat = i_dato_reg;
            default: load_dat = i_dato_mem_datos;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        section_d  = section_q;
        item_d     = item_q;
        pc_snap_d  = pc_snap_q;
        cyc_snap_d = cyc_snap_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start_dump) begin
                    pc_snap_d  = i_pc;
                    cyc_snap_d = i_contador_ciclos;
                    section_d  = SEC_PC;
                    item_d     = '0;
                    state_d    = ST_FETCH;
                end
            end
            ST_FETCH:   state_d = ST_WAIT_RD;
            ST_WAIT_RD: state_d = ST_LOAD;
            ST_LOAD:    state_d = ST_SEND;
            // The serializer runs SEND/WAIT_TX/NEXT per byte; the top waits here for the whole word.
            ST_SEND: begin
                if (word_done) begin
                    state_d = ST_FETCH;
                    item_d  = '0;
                    case (section_q)
                        SEC_PC:  section_d = SEC_CYC;
                        SEC_CYC: section_d = SEC_REG;
                        SEC_REG: begin
                            if (item_q == LAST_REG) section_d = SEC_MEM;
                            else                    item_d    = item_q + ITEM_W'(1);
                        end
                        default: begin
                            if (item_q == LAST_MEM) begin
                                item_d  = item_q;
                                state_d = ST_DONE;
                            end else begin
                                item_d = item_q + ITEM_W'(1);
                            end
                        end
                    endcase
                end
            end
            default:    state_d = ST_IDLE;
        endcase

        addr_reg_d = addr_reg_q;
        addr_mem_d = addr_mem_q;
        if (state_d == ST_FETCH) begin
            addr_reg_d = (section_d == SEC_REG) ? ADDR_REG_LENGTH'(item_d) : '0;
            addr_mem_d = (section_d == SEC_MEM) ? ADDR_MEM_DATOS_LENGTH'(item_d) : '0;
        end else if (state_d == ST_DONE) begin
            addr_reg_d = '0;
            addr_mem_d = '0;
        end

        busy_d = !(state_d inside {ST_IDLE, ST_DONE});
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            section_q  <= SEC_PC;
            item_q     <= '0;
            pc_snap_q  <= '0;
            cyc_snap_q <= '0;
            addr_reg_q <= '0;
            addr_mem_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            section_q  <= section_d;
            item_q     <= item_d;
            pc_snap_q  <= pc_snap_d;
            cyc_snap_q <= cyc_snap_d;
            addr_reg_q <= addr_reg_d;
            addr_mem_q <= addr_mem_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    debug_word_serializer #(
        .DAT_W (LONGITUD_DATO),
        .OUT_W (OUTPUT_WORD_LENGTH)
    ) u_ser (
        .clk       (i_clock),
        .rst       (i_reset),
        .load_vld  (load_vld),
        .load_dat  (load_dat),
        .tx_done   (i_tx_done),
        .tx_start  (o_tx_start),
        .tx_dat    (o_data_tx),
        .word_done (word_done)
    );

    assign o_addr_reg       = addr_reg_q;
    assign o_addr_mem_datos = addr_mem_q;
    assign o_busy           = busy_q;
    assign o_dump_done      = done_q;

endmodule
